// File: rtl/instruction_loader_pkg.sv
// loader_pkg: loader state encoding and default protocol bytes shared with
// the debugger and host tooling.
//   state_t          : IDLE, COUNT, DATA, REPLY
//   DEFAULT_CMD_LOAD : command byte that starts a load
//   DEFAULT_ACK_BYTE : reply on successful load
//   DEFAULT_NAK_BYTE : reply on aborted load
package loader_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DATA, REPLY} state_t;
  localparam logic [7:0] DEFAULT_CMD_LOAD = 8'h01;
  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
  localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h55;
endpackage

// File: rtl/instruction_loader_if.sv
// instruction_loader_if: UART byte stream, reply channel and instruction-memory
// write port of the loader.
//   master : loader side (consumes rx bytes/tx_busy, drives writes, reply, status)
//   slave  : environment side (UART receiver/transmitter, memory, pipeline)
interface instruction_loader_if #(
  parameter int SIZE = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [7:0] rx_data;
  logic rx_valid;
  logic tx_busy;
  logic [7:0] tx_data;
  logic tx_start;
  logic inst_write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [SIZE-1:0] write_data;
  logic writing_instruction_mem;
  logic load_done;
  logic error;
  modport master (
    input rx_data, rx_valid, tx_busy,
    output tx_data, tx_start, inst_write_enable, write_addr, write_data,
    output writing_instruction_mem, load_done, error
  );
  modport slave (
    output rx_data, rx_valid, tx_busy,
    input tx_data, tx_start, inst_write_enable, write_addr, write_data,
    input writing_instruction_mem, load_done, error
  );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// word_assembler: shifts bytes in MSB first and flags the byte that completes a word.
//   i_clk, i_rst : clock, asynchronous active-low reset
//   clear        : drop any partial word and restart at byte 0
//   valid, data  : byte strobe and byte
//   complete     : this byte completes a word (combinational)
//   word         : the word including the current byte
module word_assembler #(
  parameter int SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            clear,
  input  logic            valid,
  input  logic [7:0]      data,
  output logic            complete,
  output logic [SIZE-1:0] word
);
  localparam int BYTES = SIZE / 8;
  localparam int IW = $clog2(BYTES);
  logic [SIZE-9:0] shift;
  logic [IW-1:0] idx;
  assign word = {shift, data};
  assign complete = valid && idx == IW'(BYTES - 1);
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      shift <= '0;
      idx <= '0;
    end else if (clear) begin
      shift <= '0;
      idx <= '0;
    end else if (valid) begin
      shift <= word[SIZE-9:0];
      idx <= complete ? '0 : idx + IW'(1);
    end
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: assembles a UART byte stream into big-endian words, writes them to
// instruction memory while stalling the pipeline, and replies ACK/NAK.
//   i_clk, i_rst : clock, asynchronous active-low reset
//   bus (master) : rx byte stream, tx reply, memory write port, stall and status pulses
// Optional macro LOADER_TIMEOUT_EN: aborts a load after TIMEOUT_CYCLES without a byte.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter logic [7:0] CMD_LOAD = DEFAULT_CMD_LOAD,
  parameter logic [7:0] ACK_BYTE = DEFAULT_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE = DEFAULT_NAK_BYTE,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic i_clk,
  input logic i_rst,
  instruction_loader_if.master bus
);
  localparam int CW = $clog2(MAX_INSTRUCTION + 1);
  // N arrives as a single byte, and the timeout needs at least one idle cycle to count.
  if (MAX_INSTRUCTION < 1 || MAX_INSTRUCTION > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("instruction_loader: unsupported MAX_INSTRUCTION or TIMEOUT_CYCLES");
  end
  state_t state, next;
  logic [CW-1:0] count_n, words;
  logic [ADDR_WIDTH-1:0] addr;
  logic [SIZE-1:0] word;
  logic ack, complete, last, bad_n, abort, timeout;
  word_assembler #(.SIZE(SIZE)) u_asm (
    .i_clk,
    .i_rst,
    .clear(state != DATA),
    .valid(bus.rx_valid && state == DATA),
    .data(bus.rx_data),
    .complete,
    .word
  );
  assign last = words + CW'(1) == count_n;
  assign bad_n = bus.rx_data == 8'd0 || int'(bus.rx_data) > MAX_INSTRUCTION;
  assign abort = (state == COUNT && bus.rx_valid && bad_n) || timeout;
`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cycles;
  logic active;
  assign active = state == COUNT || state == DATA;
  assign timeout = active && !bus.rx_valid && idle_cycles == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) idle_cycles <= '0;
    else idle_cycles <= !active || bus.rx_valid ? '0 : idle_cycles + TW'(1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= IDLE;
    else state <= next;
  // The reply is a Mealy output so it can fire in the first non-busy REPLY cycle,
  // letting the stall drop on the following edge.
  always_comb begin
    next = state;
    bus.tx_start = 1'b0;
    case (state)
      IDLE: next = bus.rx_valid && bus.rx_data == CMD_LOAD ? COUNT : IDLE;
      COUNT: next = abort ? REPLY : bus.rx_valid ? DATA : COUNT;
      DATA: next = timeout || (complete && last) ? REPLY : DATA;
      REPLY: begin
        bus.tx_start = !bus.tx_busy;
        next = bus.tx_busy ? REPLY : IDLE;
      end
      default: next = IDLE;
    endcase
    bus.tx_data = bus.tx_start ? (ack ? ACK_BYTE : NAK_BYTE) : 8'd0;
    bus.load_done = bus.tx_start && ack;
    bus.error = bus.tx_start && !ack;
    bus.writing_instruction_mem = state != IDLE;
  end
  // Write port outputs are zero outside the single strobe cycle.
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      count_n <= '0;
      words <= '0;
      addr <= '0;
      ack <= 1'b0;
      bus.inst_write_enable <= 1'b0;
      bus.write_addr <= '0;
      bus.write_data <= '0;
    end else begin
      bus.inst_write_enable <= complete;
      bus.write_addr <= complete ? addr : '0;
      bus.write_data <= complete ? word : '0;
      if (abort) begin
        count_n <= '0;
        words <= '0;
        addr <= '0;
        ack <= 1'b0;
      end else if (state == COUNT && bus.rx_valid) begin
        count_n <= CW'(bus.rx_data);
        words <= '0;
        addr <= '0;
        ack <= 1'b0;
      end else if (complete) begin
        words <= words + CW'(1);
        addr <= addr + ADDR_WIDTH'(4);
        ack <= last;
      end
    end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Byte-stream loader that sits between the UART receiver and instruction fetch. It assembles received bytes into 32-bit big-endian instruction words and writes them sequentially into instruction memory through the IF write port. While a load is active it holds the pipeline stalled. It reports completion or failure with one acknowledge byte to the UART transmitter.

## Interface
Parameters:
- `SIZE`, 32: instruction word width.
- `ADDR_WIDTH`, 32: instruction-memory byte address width.
- `MAX_INSTRUCTION`, 64: maximum words per load.
- `CMD_LOAD`, 8'h01: command byte that starts a load.
- `ACK_BYTE`, 8'hAA / `NAK_BYTE`, 8'h55: reply bytes.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte timeout. Only used with `LOADER_TIMEOUT_EN`.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: asynchronous, active-low reset.
- `i_rx_data`, in, 8: received byte.
- `i_rx_valid`, in, 1: one-cycle strobe; `i_rx_data` is valid in that cycle.
- `i_tx_busy`, in, 1: UART transmitter busy.
- `o_tx_data`, out, 8: reply byte.
- `o_tx_start`, out, 1: one-cycle transmit request.
- `o_inst_write_enable`, out, 1: one-cycle instruction-memory write strobe.
- `o_write_addr`, out, ADDR_WIDTH: byte address of the word being written.
- `o_write_data`, out, SIZE: the word being written.
- `o_writing_instruction_mem`, out, 1: load in progress; stalls the pipeline.
- `o_load_done`, out, 1: one-cycle pulse on successful completion.
- `o_error`, out, 1: one-cycle pulse on abort.

## Operation
State machine: IDLE → COUNT → DATA → REPLY → IDLE.
- IDLE
  - A byte equal to `CMD_LOAD` moves to COUNT.
  - Any other byte is ignored.
- COUNT
  - The received byte is N, the number of words.
  - 1 ≤ N ≤ MAX_INSTRUCTION: latch N, clear the address and byte index, go to DATA.
  - N = 0 or N > MAX_INSTRUCTION: abort.
- DATA
  - Bytes are shifted in MSB first: `word <= {word[23:0], byte}`.
  - The edge that samples the 4th byte of a word registers `o_write_data`, `o_write_addr` and `o_inst_write_enable=1` for exactly one cycle.
  - After each write, the address advances by 4 and the word counter increments.
  - Once N words have been written, go to REPLY with ACK.
- REPLY
  - Wait while `i_tx_busy`=1.
  - In the first cycle with `i_tx_busy`=0, assert `o_tx_start`=1 for one cycle with `o_tx_data` set to ACK or NAK.
  - In that same cycle, pulse `o_load_done` (ACK) or `o_error` (NAK), then go to IDLE.
- Abort: clears the counters and goes to REPLY with NAK. No further writes are issued.
- `o_writing_instruction_mem`:
  - High in COUNT, DATA and REPLY; low in IDLE.
  - Already-written words remain in memory after an abort.
- Bytes received in REPLY are dropped.
- A `CMD_LOAD` value received inside DATA is treated as data.
- Word counter width is `$clog2(MAX_INSTRUCTION+1)`.
- Address wraps modulo 2^ADDR_WIDTH; wrap is unreachable under the N limit.

## Timing
- All outputs reset to 0 and the state resets to IDLE.
- Reset mid-load takes effect immediately. Nothing further is written and no reply is sent.
- Write latency: `o_inst_write_enable` is high in the cycle after the 4th `i_rx_valid` of a word.
- `i_rx_valid` in the same cycle as a write strobe is accepted as byte 0 of the next word. Back-to-back bytes are legal.
- The last write strobe and the REPLY entry share the same edge. The earliest `o_tx_start` is the following cycle.
- `o_writing_instruction_mem` falls on the edge after `o_tx_start`.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - A counter runs in COUNT and DATA and is cleared on every `i_rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`-1 with no byte received, the load aborts (NAK, `o_error`).
- Not defined: no counter exists, and the loader waits indefinitely for bytes.

## Structure
- Shared package `loader_pkg`: state enum (IDLE, COUNT, DATA, REPLY) and the default `CMD_LOAD`/`ACK_BYTE`/`NAK_BYTE` constants, so the debugger and host tooling agree on them.
- Sub-module `word_assembler`: 4-byte shift register with byte index; emits a word-complete strobe and the assembled word.
- FSM, counters, address and reply logic stay in `instruction_loader`.

## Test plan
- CMD 0x01, N=2, bytes 20 08 00 05 00 00 00 0C → two writes: addr 0x0 data 0x20080005, then addr 0x4 data 0x0000000C. Each strobe is 1 cycle. Then `o_tx_data`=0xAA and `o_load_done` pulses.
- N=0 → no writes, reply 0x55, `o_error` pulses. Same for N=65 with MAX_INSTRUCTION=64.
- Stray 0x37 in IDLE → ignored. Outputs stay 0 and `o_writing_instruction_mem` stays 0.
- `i_tx_busy`=1 held for 10 cycles at the end of a load → `o_tx_start` is delayed until the first free cycle, and the stall is held throughout.
- `i_rst` driven low after 6 data bytes → all outputs 0 immediately. No 2nd write and no reply. A fresh load then completes correctly from addr 0.
- With `LOADER_TIMEOUT_EN` and TIMEOUT_CYCLES=100, stop after 3 data bytes → `o_error` and NAK; no write strobe.
